// File: rtl/motor_ramp_sweep.sv
// Motor test-pattern generator: sawtooth/triangle duty sweeps with coast dead-time before every reversal.
// All outputs registered (EN seen at edge k drives outputs at edge k); no backpressure, runs freely while EN is high.
module motor_ramp_sweep #(
    parameter int DUTY_W   = 8,
    parameter int STEP     = 1,
    parameter int PRESCALE = 1,
    parameter int DEADTIME = 16,
    parameter int MAX_DUTY = 2**DUTY_W - 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              TRIANGLE,
    output logic [1:0]        Mode,
    output logic [DUTY_W-1:0] Duty,
    output logic              Busy,
    output logic              Dir_Flip
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W:0]   MAX_X     = (DUTY_W+1)'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(MAX_DUTY);
    localparam logic [PW-1:0]     PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0]     DEAD_LAST = DW'(DEADTIME - 1);

    localparam logic [1:0] MODE_COAST = 2'b00;
    localparam logic [1:0] MODE_FWD   = 2'b01;
    localparam logic [1:0] MODE_REV   = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        DEAD      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic              tri_sel_q, tri_sel_d;
    logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
    logic [DW-1:0]     dead_cnt_q, dead_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [1:0]        mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              flip_q, flip_d;

    logic              tick;
    logic [DUTY_W:0]   duty_sum;
    logic [DUTY_W-1:0] duty_up;
    logic [DUTY_W-1:0] duty_dn;

    // Saturating step arithmetic: the sum carries one extra bit so it can never wrap.
    always_comb begin
        tick     = (pre_cnt_q == PRE_LAST);
        duty_sum = {1'b0, duty_q} + STEP_X;
        duty_up  = (duty_sum > MAX_X) ? MAX_D : duty_sum[DUTY_W-1:0];
        duty_dn  = (duty_q > STEP_D) ? (duty_q - STEP_D) : '0;
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        tri_sel_d  = tri_sel_q;
        pre_cnt_d  = pre_cnt_q;
        dead_cnt_d = dead_cnt_q;
        duty_d     = duty_q;
        flip_d     = 1'b0;

        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (EN) begin
                    state_d   = RAMP_UP;
                    dir_d     = 1'b0;
                    tri_sel_d = TRIANGLE;
                    pre_cnt_d = '0;
                end
            end
            RAMP_UP: begin
                pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);
                if (tick) begin
                    if (duty_q == MAX_D) begin
                        if (tri_sel_q) begin
                            state_d = RAMP_DOWN;
                        end else begin
                            state_d    = DEAD;
                            duty_d     = '0;
                            dead_cnt_d = '0;
                        end
                    end else begin
                        duty_d = duty_up;
                    end
                end
            end
            RAMP_DOWN: begin
                pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);
                if (tick) begin
                    if (duty_q == '0) begin
                        state_d    = DEAD;
                        dead_cnt_d = '0;
                    end else begin
                        duty_d = duty_dn;
                    end
                end
            end
            DEAD: begin
                duty_d = '0;
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d   = RAMP_UP;
                    dir_d     = ~dir_q;
                    tri_sel_d = TRIANGLE;
                    pre_cnt_d = '0;
                    flip_d    = 1'b1;
                end else begin
                    dead_cnt_d = dead_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                duty_d  = '0;
            end
        endcase

        // Dropping EN abandons whatever is in flight, including a pending dead-time.
        if ((state_q != IDLE) && !EN) begin
            state_d    = IDLE;
            dir_d      = 1'b0;
            pre_cnt_d  = '0;
            dead_cnt_d = '0;
            duty_d     = '0;
            flip_d     = 1'b0;
        end

        // Mode/Busy follow the next state so they line up with Duty on the same edge.
        if ((state_d == RAMP_UP) || (state_d == RAMP_DOWN)) begin
            mode_d = dir_d ? MODE_REV : MODE_FWD;
        end else begin
            mode_d = MODE_COAST;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            tri_sel_q  <= 1'b0;
            pre_cnt_q  <= '0;
            dead_cnt_q <= '0;
            duty_q     <= '0;
            mode_q     <= MODE_COAST;
            busy_q     <= 1'b0;
            flip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            tri_sel_q  <= tri_sel_d;
            pre_cnt_q  <= pre_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            duty_q     <= duty_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            flip_q     <= flip_d;
        end
    end

    assign Mode     = mode_q;
    assign Duty     = duty_q;
    assign Busy     = busy_q;
    assign Dir_Flip = flip_q;

endmodule

// File: tb/tb_motor_ramp_sweep.sv
// Directed bench for motor_ramp_sweep: default, saturating-triangle and minimum-corner instances.
module tb_motor_ramp_sweep;

    logic clk;
    logic rst_n;
    logic en_def, tri_def, en_tri, tri_tri, en_min, tri_min;

    logic [1:0] mode_def, mode_tri, mode_min;
    logic [7:0] duty_def, duty_tri, duty_min;
    logic       busy_def, busy_tri, busy_min;
    logic       flip_def, flip_tri, flip_min;

    int n_checks;
    int n_fail;

    motor_ramp_sweep u_def (
        .CLK(clk), .RST_N(rst_n), .EN(en_def), .TRIANGLE(tri_def),
        .Mode(mode_def), .Duty(duty_def), .Busy(busy_def), .Dir_Flip(flip_def)
    );

    motor_ramp_sweep #(.DUTY_W(8), .STEP(7), .PRESCALE(3), .DEADTIME(16), .MAX_DUTY(200)) u_tri (
        .CLK(clk), .RST_N(rst_n), .EN(en_tri), .TRIANGLE(tri_tri),
        .Mode(mode_tri), .Duty(duty_tri), .Busy(busy_tri), .Dir_Flip(flip_tri)
    );

    motor_ramp_sweep #(.DUTY_W(8), .STEP(1), .PRESCALE(1), .DEADTIME(1), .MAX_DUTY(1)) u_min (
        .CLK(clk), .RST_N(rst_n), .EN(en_min), .TRIANGLE(tri_min),
        .Mode(mode_min), .Duty(duty_min), .Busy(busy_min), .Dir_Flip(flip_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_def = 1'b0; tri_def = 1'b0;
        en_tri = 1'b0; tri_tri = 1'b0;
        en_min = 1'b0; tri_min = 1'b0;
        repeat (3) step();
        n_checks++;
        if (mode_def !== 2'b00 || duty_def !== 8'd0 || busy_def !== 1'b0 || flip_def !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: mode=%b duty=%0d busy=%b flip=%b, need 00/0/0/0",
                     mode_def, duty_def, busy_def, flip_def);
        end
        #2 rst_n = 1'b1;
        step();
        en_def = 1'b1;
        step();
        repeat (99) step();
        n_checks++;
        if (duty_def !== 8'd99 || mode_def !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_presweep: duty=%0d mode=%b, need 99/01", duty_def, mode_def);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (duty_def !== 8'd0 || mode_def !== 2'b00 || busy_def !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: duty=%0d mode=%b busy=%b, need 0/00/0", duty_def, mode_def, busy_def);
        end
        step();
        n_checks++;
        if (busy_def !== 1'b0 || mode_def !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: busy=%b mode=%b, need 0/00", busy_def, mode_def);
        end
        #3 rst_n = 1'b1;
        step();
        n_checks++;
        if (mode_def !== 2'b01 || duty_def !== 8'd0 || busy_def !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: mode=%b duty=%0d busy=%b, need 01/0/1", mode_def, duty_def, busy_def);
        end
    endtask

    task automatic test_sawtooth();
        en_def = 1'b0;
        step();
        n_checks++;
        if (busy_def !== 1'b0 || mode_def !== 2'b00) begin
            n_fail++;
            $display("FAIL saw_idle: busy=%b mode=%b, need 0/00", busy_def, mode_def);
        end
        en_def = 1'b1; tri_def = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step();
            n_checks++;
            if (mode_def !== 2'b01 || duty_def !== 8'(i) || flip_def !== 1'b0 || busy_def !== 1'b1) begin
                n_fail++;
                $display("FAIL saw_ramp[%0d]: mode=%b duty=%0d flip=%b, need 01/%0d/0", i, mode_def, duty_def, flip_def, i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (mode_def !== 2'b00 || duty_def !== 8'd0 || flip_def !== 1'b0 || busy_def !== 1'b1) begin
                n_fail++;
                $display("FAIL saw_dead[%0d]: mode=%b duty=%0d flip=%b busy=%b, need 00/0/0/1", i, mode_def, duty_def, flip_def, busy_def);
            end
        end
        step();
        n_checks++;
        if (flip_def !== 1'b1 || mode_def !== 2'b10 || duty_def !== 8'd0) begin
            n_fail++;
            $display("FAIL saw_flip: flip=%b mode=%b duty=%0d, need 1/10/0", flip_def, mode_def, duty_def);
        end
        step();
        n_checks++;
        if (flip_def !== 1'b0 || mode_def !== 2'b10 || duty_def !== 8'd1) begin
            n_fail++;
            $display("FAIL saw_rev1: flip=%b mode=%b duty=%0d, need 0/10/1", flip_def, mode_def, duty_def);
        end
    endtask

    // Per-tick duty for STEP=7, MAX=200: up to 196, saturate at 200, 200 again on the turn, down to 4, floor at 0.
    task automatic test_triangle();
        int seq [60];
        seq[0] = 0;
        for (int j = 1; j <= 28; j++) seq[j] = 7 * j;
        seq[29] = 200;
        seq[30] = 200;
        for (int j = 1; j <= 28; j++) seq[30 + j] = 200 - 7 * j;
        seq[59] = 0;
        en_tri = 1'b1; tri_tri = 1'b1;
        for (int c = 0; c < 180; c++) begin
            step();
            n_checks++;
            if (mode_tri !== 2'b01 || duty_tri !== 8'(seq[c / 3])) begin
                n_fail++;
                $display("FAIL tri_ramp[%0d]: mode=%b duty=%0d, need 01/%0d", c, mode_tri, duty_tri, seq[c / 3]);
            end
        end
        for (int c = 0; c < 16; c++) begin
            step();
            n_checks++;
            if (mode_tri !== 2'b00 || duty_tri !== 8'd0 || busy_tri !== 1'b1) begin
                n_fail++;
                $display("FAIL tri_dead[%0d]: mode=%b duty=%0d busy=%b, need 00/0/1", c, mode_tri, duty_tri, busy_tri);
            end
        end
        step();
        n_checks++;
        if (flip_tri !== 1'b1 || mode_tri !== 2'b10 || duty_tri !== 8'd0) begin
            n_fail++;
            $display("FAIL tri_flip: flip=%b mode=%b duty=%0d, need 1/10/0", flip_tri, mode_tri, duty_tri);
        end
    endtask

    task automatic test_en_drop();
        repeat (185) step();
        n_checks++;
        if (mode_tri !== 2'b00 || busy_tri !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_in_dead_pre: mode=%b busy=%b, need 00/1", mode_tri, busy_tri);
        end
        en_tri = 1'b0;
        step();
        n_checks++;
        if (busy_tri !== 1'b0 || mode_tri !== 2'b00 || duty_tri !== 8'd0 || flip_tri !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_dead: busy=%b mode=%b duty=%0d flip=%b, need 0/00/0/0", busy_tri, mode_tri, duty_tri, flip_tri);
        end
        en_tri = 1'b1;
        step();
        n_checks++;
        if (mode_tri !== 2'b01 || duty_tri !== 8'd0 || busy_tri !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_dead_restart: mode=%b duty=%0d busy=%b, need 01/0/1", mode_tri, duty_tri, busy_tri);
        end
        repeat (100) step();
        n_checks++;
        if (mode_tri !== 2'b01 || duty_tri !== 8'd179) begin
            n_fail++;
            $display("FAIL drop_down_pre: mode=%b duty=%0d, need 01/179", mode_tri, duty_tri);
        end
        en_tri = 1'b0;
        step();
        n_checks++;
        if (busy_tri !== 1'b0 || mode_tri !== 2'b00 || duty_tri !== 8'd0) begin
            n_fail++;
            $display("FAIL drop_down: busy=%b mode=%b duty=%0d, need 0/00/0", busy_tri, mode_tri, duty_tri);
        end
        en_tri = 1'b1;
        step();
        n_checks++;
        if (mode_tri !== 2'b01 || duty_tri !== 8'd0) begin
            n_fail++;
            $display("FAIL drop_down_restart: mode=%b duty=%0d, need 01/0", mode_tri, duty_tri);
        end
        repeat (3) step();
        n_checks++;
        if (duty_tri !== 8'd7) begin
            n_fail++;
            $display("FAIL drop_first_step: duty=%0d, need 7", duty_tri);
        end
        en_tri = 1'b0;
        step();
    endtask

    task automatic test_profile_latch();
        en_def = 1'b0;
        step();
        en_def = 1'b1; tri_def = 1'b0;
        step();
        repeat (100) step();
        tri_def = 1'b1;
        repeat (155) step();
        n_checks++;
        if (duty_def !== 8'd255 || mode_def !== 2'b01) begin
            n_fail++;
            $display("FAIL latch_peak: duty=%0d mode=%b, need 255/01", duty_def, mode_def);
        end
        step();
        n_checks++;
        if (mode_def !== 2'b00 || duty_def !== 8'd0) begin
            n_fail++;
            $display("FAIL latch_keep_saw: mode=%b duty=%0d, need 00/0", mode_def, duty_def);
        end
        repeat (16) step();
        n_checks++;
        if (flip_def !== 1'b1 || mode_def !== 2'b10) begin
            n_fail++;
            $display("FAIL latch_flip: flip=%b mode=%b, need 1/10", flip_def, mode_def);
        end
        repeat (255) step();
        n_checks++;
        if (duty_def !== 8'd255 || mode_def !== 2'b10) begin
            n_fail++;
            $display("FAIL latch_tri_peak: duty=%0d mode=%b, need 255/10", duty_def, mode_def);
        end
        step();
        n_checks++;
        if (duty_def !== 8'd255 || mode_def !== 2'b10) begin
            n_fail++;
            $display("FAIL latch_tri_turn: duty=%0d mode=%b, need 255/10", duty_def, mode_def);
        end
        step();
        n_checks++;
        if (duty_def !== 8'd254 || mode_def !== 2'b10) begin
            n_fail++;
            $display("FAIL latch_tri_down: duty=%0d mode=%b, need 254/10", duty_def, mode_def);
        end
        en_def = 1'b0;
        step();
    endtask

    task automatic test_min_corner();
        logic [1:0] exp_mode [8];
        logic [7:0] exp_duty [8];
        logic       exp_flip [8];
        exp_mode = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
        exp_duty = '{8'd0,  8'd1,  8'd0,  8'd0,  8'd1,  8'd0,  8'd0,  8'd1};
        exp_flip = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        en_min = 1'b1; tri_min = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            n_checks++;
            if (mode_min !== exp_mode[c] || duty_min !== exp_duty[c] || flip_min !== exp_flip[c]) begin
                n_fail++;
                $display("FAIL min_seq[%0d]: mode=%b duty=%0d flip=%b, need %b/%0d/%b",
                         c, mode_min, duty_min, flip_min, exp_mode[c], exp_duty[c], exp_flip[c]);
            end
        end
        en_min = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sawtooth();
        test_triangle();
        test_en_drop();
        test_profile_latch();
        test_min_corner();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
